// File: rtl/lsu_mem_master_pkg.sv
// Shared width codes, byte-mask constants and FSM state encoding for the LSU memory master.
package lsu_mem_master_pkg;

    localparam int RegWidth   = 64;
    localparam int ImmWidth   = 64;
    localparam int WdtTypeCnt = 4;

    localparam logic [WdtTypeCnt-1:0] Wdt8  = 4'b0001;
    localparam logic [WdtTypeCnt-1:0] Wdt16 = 4'b0010;
    localparam logic [WdtTypeCnt-1:0] Wdt32 = 4'b0100;
    localparam logic [WdtTypeCnt-1:0] Wdt64 = 4'b1000;

    localparam logic [7:0] MaskWdt8  = 8'h01;
    localparam logic [7:0] MaskWdt16 = 8'h03;
    localparam logic [7:0] MaskWdt32 = 8'h0F;
    localparam logic [7:0] MaskWdt64 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    function automatic logic [7:0] wdt_base_mask(input logic [WdtTypeCnt-1:0] wdt);
        case (wdt)
            Wdt8:    return MaskWdt8;
            Wdt16:   return MaskWdt16;
            Wdt32:   return MaskWdt32;
            Wdt64:   return MaskWdt64;
            default: return 8'h00;
        endcase
    endfunction

    // Wdt8 can never straddle a lane, so it is always aligned.
    function automatic logic is_misaligned(input logic [WdtTypeCnt-1:0] wdt,
                                           input logic [2:0]            off);
        case (wdt)
            Wdt16:   return off[0] != 1'b0;
            Wdt32:   return off[1:0] != 2'b00;
            Wdt64:   return off != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction: shift the addressed bytes down, truncate, then extend.
module lsu_load_align
    import lsu_mem_master_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]     rdata,
    input  logic [2:0]            offset,
    input  logic [WdtTypeCnt-1:0] wdt_op,
    input  logic                  sext,
    output logic [DATA_W-1:0]     result
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        result  = shifted;
        case (wdt_op)
            Wdt8:    result = {{(DATA_W-8){sext & shifted[7]}},   shifted[7:0]};
            Wdt16:   result = {{(DATA_W-16){sext & shifted[15]}}, shifted[15:0]};
            Wdt32:   result = {{(DATA_W-32){sext & shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator: latches one EXU access, drives a doubleword bus request,
// waits for the response (or times out) and hands a one-cycle completion to WBU.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int ADDR_W  = RegWidth,
    parameter int DATA_W  = ImmWidth,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_store,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [WdtTypeCnt-1:0] in_wdt_op,
    input  logic                  in_sext,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [7:0]            mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_rdata,
    output logic                  out_misalign,
    output logic                  out_buserr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [WdtTypeCnt-1:0] wdt_q;
    logic                  store_q;
    logic                  sext_q;
    logic                  misalign_q;
    logic                  buserr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  timeout_hit;
    logic [DATA_W-1:0]     load_val;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    lsu_load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata  (rdata_q),
        .offset (addr_q[2:0]),
        .wdt_op (wdt_q),
        .sext   (sext_q),
        .result (load_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wdt_q      <= '0;
            store_q    <= 1'b0;
            sext_q     <= 1'b0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        addr_q     <= in_addr;
                        wdata_q    <= in_wdata;
                        wdt_q      <= in_wdt_op;
                        store_q    <= in_is_store;
                        sext_q     <= in_sext;
                        misalign_q <= is_misaligned(in_wdt_op, in_addr[2:0]);
                        buserr_q   <= 1'b0;
                        rdata_q    <= '0;
                        cnt_q      <= '0;
                    end
                end
                REQ: begin
                    if (mem_req_ready && mem_resp_valid) rdata_q <= mem_rdata;
                end
                WAIT: begin
                    // A response in the final timeout cycle still wins over the bus error.
                    if (mem_resp_valid) begin
                        rdata_q <= mem_rdata;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (timeout_hit) buserr_q <= 1'b1;
                    end
                end
                DONE: cnt_q <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_wen       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        out_valid     = 1'b0;
        out_rdata     = '0;
        out_misalign  = 1'b0;
        out_buserr    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = is_misaligned(in_wdt_op, in_addr[2:0]) ? DONE : REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_wen       = store_q;
                mem_addr      = {addr_q[ADDR_W-1:3], 3'b000};
                if (store_q) begin
                    mem_wmask = wdt_base_mask(wdt_q) << addr_q[2:0];
                    mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
                end
                if (mem_req_ready) state_d = mem_resp_valid ? DONE : WAIT;
            end
            WAIT: begin
                if (mem_resp_valid || timeout_hit) state_d = DONE;
            end
            DONE: begin
                out_valid    = 1'b1;
                out_misalign = misalign_q;
                out_buserr   = buserr_q;
                if (!store_q && !misalign_q && !buserr_q) out_rdata = load_val;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master, built with a short timeout so bus errors are reachable.
module tb_lsu_mem_master;

    localparam logic [3:0] W8  = 4'b0001;
    localparam logic [3:0] W16 = 4'b0010;
    localparam logic [3:0] W32 = 4'b0100;
    localparam logic [3:0] W64 = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_store, in_sext;
    logic [63:0] in_addr, in_wdata;
    logic [3:0]  in_wdt_op;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        out_valid, out_misalign, out_buserr;
    logic [63:0] out_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_store    (in_is_store),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_wdt_op      (in_wdt_op),
        .in_sext        (in_sext),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_rdata      (out_rdata),
        .out_misalign   (out_misalign),
        .out_buserr     (out_buserr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [63:0] a, input logic [63:0] wd,
                         input logic [3:0] w, input logic sx);
        in_valid    = 1'b1;
        in_is_store = st;
        in_addr     = a;
        in_wdata    = wd;
        in_wdt_op   = w;
        in_sext     = sx;
        step();
        in_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if ({mem_addr, mem_wdata, mem_wmask, mem_wen} !== '0) begin n_fail++; $display("FAIL rst_req_fields: got %h %h %h %b want 0", mem_addr, mem_wdata, mem_wmask, mem_wen); end
        n_checks++; if ({out_rdata, out_misalign, out_buserr} !== '0) begin n_fail++; $display("FAIL rst_out_fields: got %h %b %b want 0", out_rdata, out_misalign, out_buserr); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_byte();
        issue(1'b0, 64'h8000_0003, 64'h0, W8, 1'b1);
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL lb_req_valid: got %b want 1", mem_req_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_in_ready_busy: got %b want 0", in_ready); end
        n_checks++; if (mem_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL lb_addr: got %h want 80000000", mem_addr); end
        n_checks++; if (mem_wen !== 1'b0 || mem_wmask !== 8'h00) begin n_fail++; $display("FAIL lb_wen_mask: got %b %h want 0 00", mem_wen, mem_wmask); end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL lb_wait1: got req=%b out=%b want 0 0", mem_req_valid, out_valid); end
        step();
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h1122_3344_5566_7788;
        step();
        mem_resp_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lb_out_valid: got %b want 1", out_valid); end
        n_checks++; if (out_rdata !== 64'h0000_0000_0000_0055) begin n_fail++; $display("FAIL lb_rdata: got %h want 0000000000000055", out_rdata); end
        step();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL lb_one_pulse: got out=%b rdy=%b want 0 1", out_valid, in_ready); end

        // Same-cycle accept and response skips WAIT entirely.
        issue(1'b0, 64'h8000_0003, 64'h0, W8, 1'b1);
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h1122_3344_8566_7788;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lb_sext_valid: got %b want 1", out_valid); end
        n_checks++; if (out_rdata !== 64'hFFFF_FFFF_FFFF_FF85) begin n_fail++; $display("FAIL lb_sext_rdata: got %h want ffffffffffffff85", out_rdata); end
        step();
    endtask

    task automatic test_store_half();
        issue(1'b1, 64'h8000_0006, 64'hABCD, W16, 1'b0);
        n_checks++; if (mem_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL sh_addr: got %h want 80000000", mem_addr); end
        n_checks++; if (mem_wmask !== 8'hC0) begin n_fail++; $display("FAIL sh_wmask: got %h want c0", mem_wmask); end
        n_checks++; if (mem_wdata !== 64'hABCD_0000_0000_0000) begin n_fail++; $display("FAIL sh_wdata: got %h want abcd000000000000", mem_wdata); end
        n_checks++; if (mem_wen !== 1'b1) begin n_fail++; $display("FAIL sh_wen: got %b want 1", mem_wen); end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        mem_resp_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sh_out_valid: got %b want 1", out_valid); end
        n_checks++; if (out_rdata !== 64'h0) begin n_fail++; $display("FAIL sh_out_rdata: got %h want 0", out_rdata); end
        step();
    endtask

    task automatic test_misalign();
        logic [63:0] addrs [3];
        logic [3:0]  wdts  [3];
        addrs[0] = 64'h8000_0002; wdts[0] = W32;
        addrs[1] = 64'h8000_0005; wdts[1] = W16;
        addrs[2] = 64'h8000_0004; wdts[2] = W64;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, addrs[i], 64'h0, wdts[i], 1'b0);
            n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ma_no_req[%0d]: got %b want 0", i, mem_req_valid); end
            n_checks++; if (out_valid !== 1'b1 || out_misalign !== 1'b1) begin n_fail++; $display("FAIL ma_flag[%0d]: got v=%b m=%b want 1 1", i, out_valid, out_misalign); end
            n_checks++; if (out_rdata !== 64'h0 || out_buserr !== 1'b0) begin n_fail++; $display("FAIL ma_data[%0d]: got %h be=%b want 0 0", i, out_rdata, out_buserr); end
            step();
            n_checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ma_after[%0d]: got v=%b r=%b want 0 0", i, out_valid, mem_req_valid); end
        end
    endtask

    task automatic test_backpressure();
        issue(1'b0, 64'h8000_0004, 64'h0, W32, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_wen !== 1'b0 || mem_wmask !== 8'h00)
                begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b a=%h w=%b m=%h want 1 80000000 0 00", i, mem_req_valid, mem_addr, mem_wen, mem_wmask); end
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accepted: got %b want 0", mem_req_valid); end
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h89AB_CDEF_0123_4567;
        step();
        mem_resp_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_rdata !== 64'h0000_0000_89AB_CDEF) begin n_fail++; $display("FAIL bp_rdata: got v=%b %h want 1 0000000089abcdef", out_valid, out_rdata); end
        step();
    endtask

    task automatic test_timeout();
        issue(1'b0, 64'h8000_0000, 64'h0, W64, 1'b0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL to_early[%0d]: got %b want 0", i, out_valid); end
            end
        end
        n_checks++; if (out_valid !== 1'b1 || out_buserr !== 1'b1) begin n_fail++; $display("FAIL to_buserr: got v=%b be=%b want 1 1", out_valid, out_buserr); end
        n_checks++; if (out_rdata !== 64'h0 || out_misalign !== 1'b0) begin n_fail++; $display("FAIL to_data: got %h m=%b want 0 0", out_rdata, out_misalign); end
        step();

        issue(1'b0, 64'h8000_0000, 64'h0, W64, 1'b0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        step();
        step();
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hCAFE_F00D_1234_5678;
        step();
        mem_resp_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_buserr !== 1'b0) begin n_fail++; $display("FAIL to_late_resp: got v=%b be=%b want 1 0", out_valid, out_buserr); end
        n_checks++; if (out_rdata !== 64'hCAFE_F00D_1234_5678) begin n_fail++; $display("FAIL to_late_rdata: got %h want cafef00d12345678", out_rdata); end
        step();
    endtask

    task automatic test_reset_mid_op();
        issue(1'b1, 64'h8000_0008, 64'h55, W8, 1'b0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rm_ctrl: got rdy=%b v=%b r=%b want 1 0 0", in_ready, out_valid, mem_req_valid); end
        n_checks++; if ({mem_addr, mem_wdata, mem_wmask, mem_wen, out_rdata} !== '0) begin n_fail++; $display("FAIL rm_fields: got %h %h %h %b %h want 0", mem_addr, mem_wdata, mem_wmask, mem_wen, out_rdata); end
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h1;
        step();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_late_resp[%0d]: got %b want 0", i, out_valid); end
            step();
        end
    endtask

    initial begin
        in_valid       = 1'b0;
        in_is_store    = 1'b0;
        in_addr        = '0;
        in_wdata       = '0;
        in_wdt_op      = '0;
        in_sext        = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        test_reset();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_backpressure();
        test_timeout();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
